// File: rtl/reg_arb_pkg.sv
// Shared types and constants for the reg_top bus arbiter.
package reg_arb_pkg;

  localparam int unsigned REG_ADDR_W = 7;
  localparam int unsigned REG_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RD_WAIT,
    RESP
  } reg_arb_state_e;

  typedef struct packed {
    logic                  wr;
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] wdata;
    logic                  id;
  } reg_cmd_t;

endpackage

// File: rtl/reg_arb_rr.sv
// Two-way round-robin picker: on contention the master other than `last` wins.
module reg_arb_rr (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] win,
  output logic       any
);

  assign any    = |req;
  assign win[0] = req[0] & (~req[1] | last);
  assign win[1] = req[1] & (~req[0] | ~last);

endmodule

// File: rtl/reg_bus_arbiter.sv
// Two-master arbiter and access sequencer for the reg_top register bus.
module reg_bus_arbiter
  import reg_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = REG_ADDR_W,
  parameter int unsigned DATA_W     = REG_DATA_W,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              m0_req_i,
  input  logic              m1_req_i,
  input  logic              m0_wr_i,
  input  logic              m1_wr_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m0_wdata_i,
  input  logic [DATA_W-1:0] m1_wdata_i,
  output logic              m0_gnt_o,
  output logic              m1_gnt_o,
  output logic              m0_rvalid_o,
  output logic              m1_rvalid_o,
  output logic [DATA_W-1:0] m0_rdata_o,
  output logic [DATA_W-1:0] m1_rdata_o,
  output logic              reg_wstrb_o,
  output logic              reg_wr_o,
  output logic [ADDR_W-1:0] reg_addr_o,
  output logic [DATA_W-1:0] reg_wdata_o,
  input  logic [DATA_W-1:0] reg_rdata_i,
  output logic              busy_o
);

  localparam logic [1:0] WAIT_LOAD = (RD_LATENCY > 0) ? 2'(RD_LATENCY - 1) : 2'd0;

  reg_arb_state_e    state_q;
  reg_cmd_t          cmd_d, cmd_q;
  logic              last_q;
  logic [1:0]        wait_q;
  logic              wstrb_q, wr_q, busy_q;
  logic [1:0]        rvalid_q;
  logic [DATA_W-1:0] rdata_q [2];
  logic [1:0]        win;
  logic              any;

  reg_arb_rr u_rr (
    .req  ({m1_req_i, m0_req_i}),
    .last (last_q),
    .win  (win),
    .any  (any)
  );

  always_comb begin
    cmd_d       = '0;
    cmd_d.id    = win[1];
    cmd_d.wr    = win[1] ? m1_wr_i : m0_wr_i;
    cmd_d.addr  = REG_ADDR_W'(win[1] ? m1_addr_i : m0_addr_i);
    cmd_d.wdata = REG_DATA_W'(win[1] ? m1_wdata_i : m0_wdata_i);
  end

  // Grant is the only combinational output; it is masked while reset is applied.
  assign m0_gnt_o    = rst_n_i && (state_q == IDLE) && win[0];
  assign m1_gnt_o    = rst_n_i && (state_q == IDLE) && win[1];
  assign m0_rvalid_o = rvalid_q[0];
  assign m1_rvalid_o = rvalid_q[1];
  assign m0_rdata_o  = rdata_q[0];
  assign m1_rdata_o  = rdata_q[1];
  assign reg_wstrb_o = wstrb_q;
  assign reg_wr_o    = wr_q;
  assign reg_addr_o  = ADDR_W'(cmd_q.addr);
  assign reg_wdata_o = DATA_W'(cmd_q.wdata);
  assign busy_o      = busy_q;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      cmd_q      <= '0;
      last_q     <= 1'b1;
      wait_q     <= '0;
      wstrb_q    <= 1'b0;
      wr_q       <= 1'b0;
      busy_q     <= 1'b0;
      rvalid_q   <= '0;
      rdata_q[0] <= '0;
      rdata_q[1] <= '0;
    end else begin
      rvalid_q <= '0;
      unique case (state_q)
        IDLE: begin
          if (any) begin
            cmd_q   <= cmd_d;
            last_q  <= cmd_d.id;
            wr_q    <= cmd_d.wr;
            wstrb_q <= cmd_d.wr;
            busy_q  <= 1'b1;
            state_q <= ACCESS;
          end
        end
        ACCESS: begin
          wstrb_q <= 1'b0;
          if (cmd_q.wr) begin
            wr_q    <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (RD_LATENCY == 0) begin
            rdata_q[cmd_q.id]  <= reg_rdata_i;
            rvalid_q[cmd_q.id] <= 1'b1;
            state_q            <= RESP;
          end else begin
            wait_q  <= WAIT_LOAD;
            state_q <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (wait_q == 2'd0) begin
            rdata_q[cmd_q.id]  <= reg_rdata_i;
            rvalid_q[cmd_q.id] <= 1'b1;
            state_q            <= RESP;
          end else begin
            wait_q <= wait_q - 2'd1;
          end
        end
        RESP: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Bench for reg_bus_arbiter: three instances (RD_LATENCY 2, 0, 3) checked against a timestamp model.
module tb_reg_bus_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_mis = 0;

  logic       rq [3][2];
  logic       wr [3][2];
  logic [6:0] ad [3][2];
  logic [7:0] wd [3][2];
  logic       gnt [3][2];
  logic       rv [3][2];
  logic [7:0] rd [3][2];
  logic       wstrb [3];
  logic       rwr [3];
  logic       busy [3];
  logic [6:0] raddr [3];
  logic [7:0] rwdata [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic int lat_of(input int k);
    return (k == 0) ? 2 : ((k == 1) ? 0 : 3);
  endfunction

  function automatic void chk(input string name, input int k, input logic [31:0] got,
                              input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s inst%0d cyc=%0d got=%0h exp=%0h", name, k, cyc, got, exp);
    end
  endfunction

  for (genvar K = 0; K < 3; K++) begin : g_inst
    localparam int unsigned L = (K == 0) ? 2 : ((K == 1) ? 0 : 3);
    logic [7:0] mem [128];
    logic [7:0] pipe [4];
    logic [7:0] rdata;
    bit         inited = 1'b0;

    reg_bus_arbiter #(.ADDR_W(7), .DATA_W(8), .RD_LATENCY(L)) u_dut (
      .clk_i       (clk),
      .rst_n_i     (rst_n),
      .m0_req_i    (rq[K][0]),
      .m1_req_i    (rq[K][1]),
      .m0_wr_i     (wr[K][0]),
      .m1_wr_i     (wr[K][1]),
      .m0_addr_i   (ad[K][0]),
      .m1_addr_i   (ad[K][1]),
      .m0_wdata_i  (wd[K][0]),
      .m1_wdata_i  (wd[K][1]),
      .m0_gnt_o    (gnt[K][0]),
      .m1_gnt_o    (gnt[K][1]),
      .m0_rvalid_o (rv[K][0]),
      .m1_rvalid_o (rv[K][1]),
      .m0_rdata_o  (rd[K][0]),
      .m1_rdata_o  (rd[K][1]),
      .reg_wstrb_o (wstrb[K]),
      .reg_wr_o    (rwr[K]),
      .reg_addr_o  (raddr[K]),
      .reg_wdata_o (rwdata[K]),
      .reg_rdata_i (rdata),
      .busy_o      (busy[K])
    );

    // reg_top stand-in: register file with an L-cycle read pipeline.
    always @(posedge clk) begin
      if (!inited) begin
        for (int i = 0; i < 128; i++) mem[i] <= 8'(i) ^ 8'h5A;
        inited <= 1'b1;
      end else if (wstrb[K]) begin
        mem[raddr[K]] <= rwdata[K];
      end
      pipe[0] <= mem[raddr[K]];
      for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
    end

    if (L == 0) begin : g_comb
      assign rdata = mem[raddr[K]];
    end else begin : g_pipe
      assign rdata = pipe[L-1];
    end
  end

  // Model: each grant schedules absolute cycles for strobe, rvalid and idle.
  int         m_free [3];
  int         m_strobe [3];
  int         m_rv [3];
  int         m_rvid [3];
  logic [7:0] m_rvdata [3];
  logic       m_last [3];
  logic [6:0] m_addr [3];
  logic [7:0] m_wdata [3];
  logic [7:0] m_rdata [3][2];
  logic [7:0] mdl_mem [3][128];
  bit         armed = 1'b0;
  bit         mem_init = 1'b0;

  always @(negedge clk) begin
    int c, w, l;
    if (!mem_init) begin
      for (int k = 0; k < 3; k++)
        for (int i = 0; i < 128; i++) mdl_mem[k][i] = 8'(i) ^ 8'h5A;
      for (int k = 0; k < 3; k++) begin
        m_free[k] = 0; m_strobe[k] = -1; m_rv[k] = -1; m_rvid[k] = 0;
      end
      mem_init = 1'b1;
    end
    c = cyc;
    for (int k = 0; k < 3; k++) begin
      l = lat_of(k);
      if (armed && c == m_rv[k]) m_rdata[k][m_rvid[k]] = m_rvdata[k];
      w = -1;
      if (c >= m_free[k] && rst_n) begin
        if (rq[k][0] && rq[k][1]) w = m_last[k] ? 0 : 1;
        else if (rq[k][0])        w = 0;
        else if (rq[k][1])        w = 1;
      end
      if (armed) begin
        chk("gnt0", k, gnt[k][0], w == 0);
        chk("gnt1", k, gnt[k][1], w == 1);
        chk("wstrb", k, wstrb[k], c == m_strobe[k]);
        chk("reg_wr", k, rwr[k], c == m_strobe[k]);
        chk("busy", k, busy[k], c < m_free[k]);
        chk("reg_addr", k, raddr[k], m_addr[k]);
        chk("reg_wdata", k, rwdata[k], m_wdata[k]);
        for (int m = 0; m < 2; m++) begin
          chk(m == 0 ? "rvalid0" : "rvalid1", k, rv[k][m], c == m_rv[k] && m_rvid[k] == m);
          chk(m == 0 ? "rdata0" : "rdata1", k, rd[k][m], m_rdata[k][m]);
        end
      end
      if (!rst_n) begin
        m_free[k] = c + 1; m_strobe[k] = -1; m_rv[k] = -1;
        m_last[k] = 1'b1; m_addr[k] = '0; m_wdata[k] = '0;
        m_rdata[k][0] = '0; m_rdata[k][1] = '0;
      end else if (w >= 0) begin
        m_last[k]  = w[0];
        m_addr[k]  = ad[k][w];
        m_wdata[k] = wd[k][w];
        if (wr[k][w]) begin
          m_strobe[k] = c + 1;
          m_free[k]   = c + 2;
          mdl_mem[k][ad[k][w]] = wd[k][w];
        end else begin
          m_rv[k]     = c + 2 + l;
          m_rvid[k]   = w;
          m_rvdata[k] = mdl_mem[k][ad[k][w]];
          m_free[k]   = c + 3 + l;
        end
      end
    end
    if (!rst_n) armed = 1'b1;
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Raise req, wait for gnt, drop req right after the grant edge; returns in the ACCESS cycle.
  task automatic do_req(input int k, input int m, input logic w, input logic [6:0] a,
                        input logic [7:0] d, output int gc);
    bit got = 1'b0;
    gc = -1;
    wr[k][m] = w; ad[k][m] = a; wd[k][m] = d; rq[k][m] = 1'b1;
    for (int i = 0; i < 40 && !got; i++) begin
      #1;
      if (gnt[k][m]) begin
        got = 1'b1;
        gc  = cyc;
      end
      @(posedge clk);
      #1;
    end
    rq[k][m] = 1'b0;
    if (!got) begin
      n_cmp++; n_mis++;
      $display("FAIL gnt_timeout inst%0d m%0d got=0 exp=1", k, m);
    end
  endtask

  task automatic wait_idle(input int k);
    bit ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (!busy[k]) ok = 1'b1;
      else tick();
    end
    if (!ok) begin
      n_cmp++; n_mis++;
      $display("FAIL idle_timeout inst%0d got=busy exp=idle", k);
    end
  endtask

  initial begin
    int g;
    int gm [$];
    int gcy [$];
    int rcy [$];
    logic [7:0] rdv [$];
    for (int k = 0; k < 3; k++)
      for (int m = 0; m < 2; m++) begin
        rq[k][m] = 1'b0; wr[k][m] = 1'b0; ad[k][m] = '0; wd[k][m] = '0;
      end
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    chk("rst_busy", 0, busy[0], 0);
    chk("rst_addr", 0, raddr[0], 0);
    chk("rst_rdata1", 0, rd[0][1], 0);
    chk("rst_wstrb", 0, wstrb[0], 0);

    // single write, master 0
    do_req(0, 0, 1'b1, 7'h05, 8'hA5, g);
    chk("wr_strobe", 0, wstrb[0], 1);
    chk("wr_addr", 0, raddr[0], 7'h05);
    chk("wr_wdata", 0, rwdata[0], 8'hA5);
    chk("wr_busy", 0, busy[0], 1);
    tick();
    chk("wr_busy_n2", 0, busy[0], 0);
    chk("wr_strobe_n2", 0, wstrb[0], 0);
    chk("mdl_mem05", 0, mdl_mem[0][5], 8'hA5);

    // read by master 1, RD_LATENCY=2 -> rvalid at N+4
    do_req(0, 1, 1'b0, 7'h05, 8'h00, g);
    tick(2);
    chk("rd_rv_n3", 0, rv[0][1], 0);
    tick();
    chk("rd_rv_n4", 0, rv[0][1], 1);
    chk("rd_data", 0, rd[0][1], 8'hA5);
    chk("rd_rv_other", 0, rv[0][0], 0);
    tick();
    chk("rd_rdata_hold", 0, rd[0][1], 8'hA5);
    chk("rd_idle", 0, busy[0], 0);

    // contention after reset: grants 0,1,0,1 every 2 cycles
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    wr[0][0] = 1'b1; ad[0][0] = 7'h20; wd[0][0] = 8'h11;
    wr[0][1] = 1'b1; ad[0][1] = 7'h21; wd[0][1] = 8'h22;
    rq[0][0] = 1'b1; rq[0][1] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (gnt[0][0]) begin gm.push_back(0); gcy.push_back(cyc); end
      if (gnt[0][1]) begin gm.push_back(1); gcy.push_back(cyc); end
      tick();
    end
    rq[0][0] = 1'b0; rq[0][1] = 1'b0;
    chk("cont_count", 0, gm.size(), 4);
    for (int i = 0; i < gm.size() && i < 4; i++) begin
      chk("cont_order", 0, gm[i], i % 2);
      if (i > 0) chk("cont_spacing", 0, gcy[i] - gcy[i-1], 2);
    end

    // drop req and change addr after gnt: access keeps 0x10, no second grant
    wait_idle(0);
    do_req(0, 0, 1'b1, 7'h10, 8'h33, g);
    ad[0][0] = 7'h7F;
    chk("drop_addr", 0, raddr[0], 7'h10);
    chk("drop_strobe", 0, wstrb[0], 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("drop_no_gnt", 0, gnt[0][0], 0);
    end

    // reset in RD_WAIT aborts the read and re-arms master 0 priority
    do_req(0, 0, 1'b0, 7'h05, 8'h00, g);
    tick();
    chk("abort_busy_pre", 0, busy[0], 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("abort_busy", 0, busy[0], 0);
    chk("abort_rv0", 0, rv[0][0], 0);
    chk("abort_addr", 0, raddr[0], 0);
    chk("abort_rdata1", 0, rd[0][1], 0);
    tick(3);
    chk("abort_no_rv", 0, rv[0][0], 0);
    wr[0][0] = 1'b1; ad[0][0] = 7'h30; wd[0][0] = 8'h44;
    wr[0][1] = 1'b1; ad[0][1] = 7'h31; wd[0][1] = 8'h55;
    rq[0][0] = 1'b1; rq[0][1] = 1'b1;
    #1;
    chk("abort_first_gnt0", 0, gnt[0][0], 1);
    chk("abort_first_gnt1", 0, gnt[0][1], 0);
    tick();
    rq[0][0] = 1'b0; rq[0][1] = 1'b0;
    wait_idle(0);

    // back-to-back reads 0x01,0x02 on the RD_LATENCY=0 and 3 instances
    chk("mdl_mem01", 1, mdl_mem[1][1], 8'h5B);
    for (int k = 1; k < 3; k++) begin
      int ng;
      bit granted;
      ng = 0;
      gcy.delete(); rcy.delete(); rdv.delete();
      wr[k][0] = 1'b0; ad[k][0] = 7'h01; rq[k][0] = 1'b1;
      for (int i = 0; i < 24; i++) begin
        #1;
        granted = gnt[k][0];
        if (granted) begin ng++; gcy.push_back(cyc); end
        if (rv[k][0]) begin rcy.push_back(cyc); rdv.push_back(rd[k][0]); end
        tick();
        if (granted && ng == 1) ad[k][0] = 7'h02;
        if (granted && ng == 2) rq[k][0] = 1'b0;
      end
      rq[k][0] = 1'b0;
      chk("sweep_gnts", k, gcy.size(), 2);
      chk("sweep_rvs", k, rcy.size(), 2);
      if (gcy.size() == 2 && rcy.size() == 2) begin
        chk("sweep_gnt_spacing", k, gcy[1] - gcy[0], 3 + lat_of(k));
        chk("sweep_rv_latency", k, rcy[0] - gcy[0], 2 + lat_of(k));
        chk("sweep_rv_spacing", k, rcy[1] - rcy[0], 3 + lat_of(k));
        chk("sweep_data0", k, rdv[0], 8'h5B);
        chk("sweep_data1", k, rdv[1], 8'h58);
      end
    end

    tick(4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
